// File: rtl/ahb_bridge_arbiter_if.sv
// Bus bundle between up to four AHB masters, the round-robin arbiter and the
// AHB-to-APB bridge slave port.
interface ahb_bridge_arbiter_if #(
    parameter int NUM_M = 3
);
    logic [NUM_M-1:0]    Hbusreq;
    logic [NUM_M-1:0]    Hlock;
    logic [2*NUM_M-1:0]  Htrans_m;
    logic [NUM_M-1:0]    Hwrite_m;
    logic [32*NUM_M-1:0] Haddr_m;
    logic [32*NUM_M-1:0] Hwdata_m;
    logic                Hreadyout;
    logic [NUM_M-1:0]    Hgrant;
    logic [1:0]          Hmaster;
    logic                Hmastlock;
    logic [1:0]          Htrans;
    logic                Hwrite;
    logic [31:0]         Haddr;
    logic [31:0]         Hwdata;
    logic                Hreadyin;

    // Arbiter side: takes master requests and bridge ready, drives grant and bridge inputs.
    modport slave (
        input  Hbusreq, Hlock, Htrans_m, Hwrite_m, Haddr_m, Hwdata_m, Hreadyout,
        output Hgrant, Hmaster, Hmastlock, Htrans, Hwrite, Haddr, Hwdata, Hreadyin
    );

    modport master (
        output Hbusreq, Hlock, Htrans_m, Hwrite_m, Haddr_m, Hwdata_m, Hreadyout,
        input  Hgrant, Hmaster, Hmastlock, Htrans, Hwrite, Haddr, Hwdata, Hreadyin
    );
endinterface

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB arbiter with hold limiting and locked tenures, steering the
// address-phase owner's controls and the data-phase owner's write data into the bridge.
module ahb_bridge_arbiter #(
    parameter int NUM_M    = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic                 Hclk,
    input  logic                 Hresetn,
    ahb_bridge_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        PARK   = 2'd0,
        OWNED  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  hmaster_q, hmaster_d;
    logic [1:0]  downer_q, downer_d;
    logic [1:0]  last_q, last_d;
    logic [3:0]  hold_q, hold_d;

    logic [3:0]  req4, lock4, write4, others4;
    logic [1:0]  trans_a [4];
    logic [31:0] addr_a  [4];
    logic [31:0] wdata_a [4];

    logic        own_req, own_lock, own_xfer, others_req, arb;
    logic [3:0]  hold_inc;
    logic        win_found;
    logic [1:0]  win_idx, cand;

    // Widen per-master inputs to four slots so a 2-bit owner index is always in range.
    always_comb begin : pad_inputs
        req4   = '0;
        lock4  = '0;
        write4 = '0;
        for (int i = 0; i < 4; i++) begin
            trans_a[i] = '0;
            addr_a[i]  = '0;
            wdata_a[i] = '0;
        end
        for (int i = 0; i < NUM_M; i++) begin
            req4[i]    = bus.Hbusreq[i];
            lock4[i]   = bus.Hlock[i];
            write4[i]  = bus.Hwrite_m[i];
            trans_a[i] = bus.Htrans_m[2*i +: 2];
            addr_a[i]  = bus.Haddr_m[32*i +: 32];
            wdata_a[i] = bus.Hwdata_m[32*i +: 32];
        end
    end

    // The hold limit counts the transfer being accepted this cycle, so a tenure is
    // exactly MAX_HOLD transfers long when others are waiting.
    always_comb begin : owner_status
        own_req    = req4[hmaster_q];
        own_lock   = lock4[hmaster_q];
        own_xfer   = trans_a[hmaster_q][1];
        others4    = req4;
        others4[hmaster_q] = 1'b0;
        others_req = |others4;
        hold_inc   = (own_xfer && hold_q != 4'(MAX_HOLD)) ? hold_q + 4'd1 : hold_q;
    end

    always_comb begin : rr_search
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            cand = 2'((int'(last_q) + k) % NUM_M);
            if (!win_found && req4[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        hmaster_d = hmaster_q;
        downer_d  = downer_q;
        last_d    = last_q;
        hold_d    = hold_q;
        arb       = 1'b0;
        if (bus.Hreadyout) begin
            downer_d = hmaster_q;
            unique case (state_q)
                PARK: arb = 1'b1;
                OWNED: begin
                    if (own_req && own_lock) begin
                        state_d = LOCKED;
                        hold_d  = hold_inc;
                    end else if (!own_req || (hold_inc == 4'(MAX_HOLD) && others_req)) begin
                        arb = 1'b1;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
                LOCKED: begin
                    if (!own_lock) state_d = OWNED;
                end
                default: state_d = PARK;
            endcase
            if (arb) begin
                hold_d = '0;
                if (win_found) begin
                    hmaster_d = win_idx;
                    last_d    = win_idx;
                    state_d   = lock4[win_idx] ? LOCKED : OWNED;
                end else begin
                    hmaster_d = '0;
                    state_d   = PARK;
                end
            end
        end
    end

    always_ff @(posedge Hclk) begin : state_reg
        if (!Hresetn) begin
            state_q   <= PARK;
            hmaster_q <= '0;
            downer_q  <= '0;
            last_q    <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            hmaster_q <= hmaster_d;
            downer_q  <= downer_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin : outputs
        bus.Hgrant = '0;
        for (int i = 0; i < NUM_M; i++) begin
            bus.Hgrant[i] = (hmaster_q == 2'(i));
        end
        bus.Hmaster   = hmaster_q;
        bus.Hmastlock = (state_q == LOCKED);
        bus.Htrans    = (state_q == PARK) ? 2'b00 : trans_a[hmaster_q];
        bus.Hwrite    = write4[hmaster_q];
        bus.Haddr     = addr_a[hmaster_q];
        bus.Hwdata    = wdata_a[downer_q];
        bus.Hreadyin  = bus.Hreadyout;
    end
endmodule
